// File: rtl/fp_pkg.sv
// Shared floating-point format constants and width helpers used by the
// small-float adders and multiplier in this slice.
package fp_pkg;

    // Default format is E2M1 (FP4): 1 sign, 2 exponent, 1 mantissa bit.
    localparam int FP_EW   = 2;
    localparam int FP_MW   = 1;
    localparam int FP_BIAS = (1 << (FP_EW - 1)) - 1;

    // Guard, round and sticky bits kept below the significand.
    localparam int GRS_W   = 3;

    // Total encoded width {sign, exp, mant}.
    function automatic int fp_width(input int ew, input int mw);
        return 1 + ew + mw;
    endfunction

    // Significand width including the hidden bit.
    function automatic int sig_width(input int mw);
        return mw + 1;
    endfunction

    // Exponent bias for a given exponent field width.
    function automatic int bias_of(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_lzc_norm.sv
// Leading-zero count and normalise shift for the adder's final stage.
// Takes the raw aligned sum (carry bit on top, GRS at the bottom) and the
// exponent of the larger operand, and returns a significand with the hidden
// bit in the top position (or a subnormal if the exponent floor is reached).
module fp_lzc_norm
    import fp_pkg::*;
#(
    parameter int EW = FP_EW,
    parameter int MW = FP_MW
) (
    input  logic [MW+GRS_W+1:0] sum,
    input  logic [EW-1:0]       exp_in,
    output logic [MW+GRS_W:0]   norm,
    output logic [EW:0]         exp_out
);

    localparam int SIG_W = sig_width(MW);
    localparam int XW    = SIG_W + GRS_W;
    localparam int XEW   = EW + 1;

    logic [XW-1:0] body;
    int            lz;
    int            lim;
    int            sh;

    // Carry-out shifts right by one (folding the lost bit into sticky);
    // otherwise shift left by the leading-zero count, stopping at exponent 1.
    always_comb begin
        body    = sum[XW-1:0];
        lz      = XW;
        lim     = 0;
        sh      = 0;
        norm    = '0;
        exp_out = '0;
        for (int i = 0; i < XW; i++) begin
            if (body[i]) lz = XW - 1 - i;
        end
        if (sum[XW]) begin
            norm    = {sum[XW:2], sum[1] | sum[0]};
            exp_out = {1'b0, exp_in} + XEW'(1);
        end else begin
            lim     = int'(exp_in) - 1;
            sh      = (lz < lim) ? lz : lim;
            norm    = body << sh;
            exp_out = {1'b0, exp_in} - XEW'(sh);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Pipelined small-float adder/subtractor with a sideband tag.
// Operand register, then S1 (sign, compare/swap, align with GRS),
// S2 (mantissa add/sub), S3 (normalise, round-to-nearest-even, pack).
//
// Handshake: a transfer happens on a rising edge only when valid and ready
// are both high on that side. Every register moves together on
// adv = !s3_v || out_ready, so in_ready is simply adv; bubbles are never
// squeezed out, and a stalled result holds out/out_tag/out_ovf steady.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EW    = FP_EW,
    parameter int MW    = FP_MW,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EW+MW:0]   a,
    input  logic [EW+MW:0]   b,
    input  logic             sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EW+MW:0]   out,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf
);

    localparam int W     = fp_width(EW, MW);
    localparam int SIG_W = sig_width(MW);
    localparam int XW    = SIG_W + GRS_W;
    localparam int SW    = XW + 1;
    localparam int XEW   = EW + 1;

    logic adv;
    logic s0_v, s1_v, s2_v, s3_v;

    assign adv       = !s3_v || out_ready;
    assign in_ready  = adv;
    assign out_valid = s3_v;

    // Valid chain: all stages step together on adv, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v <= 1'b0;
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else if (adv) begin
            s0_v <= in_valid;
            s1_v <= s0_v;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
    end

    // ---------------- operand register ----------------
    logic [W-1:0]     s0_a, s0_b;
    logic             s0_sub;
    logic [TAG_W-1:0] s0_tag;

    // Capture operands, opcode and tag on each advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_a   <= '0;
            s0_b   <= '0;
            s0_sub <= 1'b0;
            s0_tag <= '0;
        end else if (adv) begin
            s0_a   <= a;
            s0_b   <= b;
            s0_sub <= sub;
            s0_tag <= in_tag;
        end
    end

    // ---------------- S1: sign, compare/swap, align ----------------
    logic          sa, sb_eff, swap, l_sign, eff_sub;
    logic [EW-1:0] l_ef, s_ef, l_e, s_e, diff;
    logic [MW-1:0] l_m, s_m;
    logic [XW-1:0] l_ext, s_ext, s_shift, s_lost, s_al;

    // Larger magnitude goes to L; smaller is right-shifted with sticky collection.
    always_comb begin
        sa      = s0_a[W-1];
        sb_eff  = s0_b[W-1] ^ s0_sub;
        swap    = s0_b[W-2:0] > s0_a[W-2:0];
        l_ef    = swap ? s0_b[W-2 -: EW] : s0_a[W-2 -: EW];
        s_ef    = swap ? s0_a[W-2 -: EW] : s0_b[W-2 -: EW];
        l_m     = swap ? s0_b[MW-1:0]    : s0_a[MW-1:0];
        s_m     = swap ? s0_a[MW-1:0]    : s0_b[MW-1:0];
        l_sign  = swap ? sb_eff : sa;
        eff_sub = sa ^ sb_eff;
        // Subnormals (exp field 0) behave as exponent 1 with no hidden bit.
        l_e     = (l_ef == '0) ? EW'(1) : l_ef;
        s_e     = (s_ef == '0) ? EW'(1) : s_ef;
        diff    = l_e - s_e;
        l_ext   = {l_ef != '0, l_m, {GRS_W{1'b0}}};
        s_ext   = {s_ef != '0, s_m, {GRS_W{1'b0}}};
        s_shift = s_ext >> diff;
        s_lost  = s_ext & ~({XW{1'b1}} << diff);
        s_al    = {s_shift[XW-1:1], s_shift[0] | (|s_lost)};
    end

    logic             s1_sign, s1_zsign, s1_eff_sub;
    logic [EW-1:0]    s1_exp;
    logic [XW-1:0]    s1_l, s1_s;
    logic [TAG_W-1:0] s1_tag;

    // Register aligned operands; exact-zero sign is +0 unless both signs agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign    <= 1'b0;
            s1_zsign   <= 1'b0;
            s1_eff_sub <= 1'b0;
            s1_exp     <= '0;
            s1_l       <= '0;
            s1_s       <= '0;
            s1_tag     <= '0;
        end else if (adv) begin
            s1_sign    <= l_sign;
            s1_zsign   <= eff_sub ? 1'b0 : l_sign;
            s1_eff_sub <= eff_sub;
            s1_exp     <= l_e;
            s1_l       <= l_ext;
            s1_s       <= s_al;
            s1_tag     <= s0_tag;
        end
    end

    // ---------------- S2: add / subtract ----------------
    logic [SW-1:0] sum_c;

    // L is never smaller than the aligned S, so subtraction cannot go negative.
    always_comb begin
        sum_c = s1_eff_sub ? ({1'b0, s1_l} - {1'b0, s1_s})
                           : ({1'b0, s1_l} + {1'b0, s1_s});
    end

    logic             s2_sign, s2_zsign;
    logic [EW-1:0]    s2_exp;
    logic [SW-1:0]    s2_sum;
    logic [TAG_W-1:0] s2_tag;

    // Register the raw sum with its exponent and sign.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sign  <= 1'b0;
            s2_zsign <= 1'b0;
            s2_exp   <= '0;
            s2_sum   <= '0;
            s2_tag   <= '0;
        end else if (adv) begin
            s2_sign  <= s1_sign;
            s2_zsign <= s1_zsign;
            s2_exp   <= s1_exp;
            s2_sum   <= sum_c;
            s2_tag   <= s1_tag;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [XW-1:0]  norm;
    logic [XEW-1:0] nexp;

    fp_lzc_norm #(
        .EW (EW),
        .MW (MW)
    ) u_norm (
        .sum     (s2_sum),
        .exp_in  (s2_exp),
        .norm    (norm),
        .exp_out (nexp)
    );

    logic             rup, hidden, ovf_c;
    logic [SIG_W:0]   rsig;
    logic [XEW-1:0]   fexp;
    logic [EW-1:0]    efield;
    logic [W-1:0]     res_c;

    // Round to nearest even; a significand carry bumps the exponent, and any
    // exponent beyond the top encoding saturates to max finite.
    always_comb begin
        rup    = norm[2] & (norm[1] | norm[0] | norm[GRS_W]);
        rsig   = {1'b0, norm[XW-1:GRS_W]} + {{SIG_W{1'b0}}, rup};
        fexp   = nexp + {{EW{1'b0}}, rsig[SIG_W]};
        hidden = rsig[SIG_W] | rsig[SIG_W-1];
        efield = hidden ? fexp[EW-1:0] : '0;
        ovf_c  = 1'b0;
        if (s2_sum == '0) begin
            res_c = {s2_zsign, {(W-1){1'b0}}};
        end else if (fexp > {1'b0, {EW{1'b1}}}) begin
            res_c = {s2_sign, {(W-1){1'b1}}};
            ovf_c = 1'b1;
        end else begin
            res_c = {s2_sign, efield, rsig[MW-1:0]};
        end
    end

    logic [W-1:0]     s3_out;
    logic             s3_ovf;
    logic [TAG_W-1:0] s3_tag;

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_out <= '0;
            s3_ovf <= 1'b0;
            s3_tag <= '0;
        end else if (adv) begin
            s3_out <= res_c;
            s3_ovf <= ovf_c;
            s3_tag <= s2_tag;
        end
    end

    assign out     = s3_out;
    assign out_ovf = s3_ovf;
    assign out_tag = s3_tag;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: default E2M1 instance plus an E4M3 instance.
module tb_fp_addsub_pipe;

    localparam int TW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default E2M1 instance
    logic          in_valid, in_ready, sub, out_valid, out_ready, out_ovf;
    logic [3:0]    a, b, out;
    logic [TW-1:0] in_tag, out_tag;

    // E4M3 instance
    logic          w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_out_ovf;
    logic [7:0]    w_a, w_b, w_out;
    logic [TW-1:0] w_in_tag, w_out_tag;

    int n_cmp = 0;
    int n_err = 0;
    int n_out0 = 0;

    logic [15:0] exp_q[$];
    logic [15:0] w_q[$];

    fp_addsub_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_tag(out_tag), .out_ovf(out_ovf)
    );

    fp_addsub_pipe #(.EW(4), .MW(3), .TAG_W(TW)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .sub(w_sub), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out(w_out), .out_tag(w_out_tag), .out_ovf(w_out_ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] t, input logic [8:0] r);
        return {3'b000, t, r};
    endfunction

    // ---------------- reference model ----------------
    // Magnitude as an integer count of the smallest subnormal step.
    function automatic longint fp_mag(input int ew, input int mw, input logic [7:0] x);
        int xi, ef, mf;
        xi = int'(x);
        ef = (xi >> mw) & ((1 << ew) - 1);
        mf = xi & ((1 << mw) - 1);
        if (ef == 0) return longint'(mf);
        return longint'((1 << mw) | mf) << (ef - 1);
    endfunction

    // Returns {ovf, encoded result}.
    function automatic logic [8:0] fp_ref(input int ew, input int mw,
                                         input logic [7:0] x, input logic [7:0] y,
                                         input logic s);
        int sx, sy, k, e, msb, bw, sg;
        longint mx, my, v, m, q, rem, half;
        logic [7:0] r;
        bw = ew + mw;
        sx = (int'(x) >> bw) & 1;
        sy = ((int'(y) >> bw) & 1) ^ int'(s);
        mx = fp_mag(ew, mw, x);
        my = fp_mag(ew, mw, y);
        v  = ((sx != 0) ? -mx : mx) + ((sy != 0) ? -my : my);
        if (v == 0) begin
            r = (sx == sy) ? 8'(sx << bw) : 8'd0;
            return {1'b0, r};
        end
        sg = (v < 0) ? 1 : 0;
        m  = (v < 0) ? -v : v;
        q  = m;
        if (m >= (longint'(1) << (mw + 1))) begin
            msb = 0;
            for (int i = 0; i < 62; i++) if ((m >> i) != 0) msb = i;
            k    = msb - mw;
            q    = m >> k;
            rem  = m & ((longint'(1) << k) - 1);
            half = longint'(1) << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << (mw + 1))) begin
                q = q >> 1;
                k = k + 1;
            end
            e = k + 1;
            if (e > (1 << ew) - 1) begin
                r = 8'((sg << bw) | ((1 << bw) - 1));
                return {1'b1, r};
            end
            q = (longint'(e) << mw) | (q & ((longint'(1) << mw) - 1));
        end
        r = 8'(q) | 8'(sg << bw);
        return {1'b0, r};
    endfunction

    // ---------------- drivers ----------------
    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send0(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                         input logic [3:0] tt, input logic [15:0] e);
        int waited = 0;
        a = ta; b = tb; sub = ts; in_tag = tt; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        else exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                         input logic [3:0] tt, input logic [15:0] e);
        int waited = 0;
        w_a = ta; w_b = tb; w_sub = ts; w_in_tag = tt; w_in_valid = 1'b1;
        @(negedge clk);
        while (!w_in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!w_in_ready) check("w_in_ready_timeout", 32'(w_in_ready), 32'd1);
        else w_q.push_back(e);
        @(posedge clk); #1;
        w_in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int cyc = 0;
        while ((exp_q.size() != 0 || w_q.size() != 0) && cyc < 200) begin
            cyc++;
            @(posedge clk);
        end
        #1;
        check(nm, 32'(exp_q.size() + w_q.size()), 32'd0);
    endtask

    task automatic lat_check(input string nm);
        int cyc = 0;
        while (cyc < 10) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (out_valid) break;
        end
        check(nm, 32'(cyc), 32'd3);
    endtask

    // ---------------- scoreboards ----------------
    logic        prev_stall = 1'b0;
    logic [15:0] prev_obs;

    always @(negedge clk) begin
        logic [15:0] obs;
        obs = {3'b000, out_tag, out_ovf, 4'b0000, out};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", 32'(obs), 32'(prev_obs));
            if (out_valid && out_ready) begin
                n_out0++;
                if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
                else check("result", 32'(obs), 32'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_obs   = obs;
        end
    end

    always @(negedge clk) begin
        if (!rst && w_out_valid && w_out_ready) begin
            if (w_q.size() == 0) check("w_spurious_out", 32'(w_out_valid), 32'd0);
            else check("w_result", 32'({3'b000, w_out_tag, w_out_ovf, w_out}),
                       32'(w_q.pop_front()));
        end
    end

    // ---------------- directed vectors (hand-computed) ----------------
    localparam int ND = 14;
    logic [3:0] d_a   [ND] = '{4'h5, 4'hD, 4'h3, 4'h7, 4'h1, 4'h8, 4'h0,
                               4'h1, 4'h5, 4'hF, 4'h6, 4'h7, 4'h7, 4'h4};
    logic [3:0] d_b   [ND] = '{4'h3, 4'h3, 4'h2, 4'h7, 4'h1, 4'h8, 4'h0,
                               4'h1, 4'h1, 4'h7, 4'h1, 4'h1, 4'h3, 4'h1};
    logic       d_s   [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] d_o   [ND] = '{4'h6, 4'hE, 4'h4, 4'h7, 4'h0, 4'h8, 4'h0,
                               4'h2, 4'h6, 4'hF, 4'h6, 4'h7, 4'h7, 4'h4};
    logic       d_v   [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    // ---------------- main sequence ----------------
    initial begin
        logic saw_drop;
        logic sweep_done;
        int   outs_before;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; in_tag = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0; w_in_tag = '0; w_out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // first op alone: latency 3 with value check
        send0(d_a[0], d_b[0], d_s[0], 4'd0, mk(4'd0, {d_v[0], 4'h0, d_o[0]}));
        lat_check("latency_first");
        drain("drain_first");
        @(posedge clk); #1;

        // directed vectors back to back
        for (int i = 1; i < ND; i++)
            send0(d_a[i], d_b[i], d_s[i], 4'(i), mk(4'(i), {d_v[i], 4'h0, d_o[i]}));
        drain("drain_directed");

        // stream of 8 with a 5-cycle output stall
        saw_drop = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [3:0] xa, xb;
                    xa = 4'(i + 1);
                    xb = 4'(7 - i);
                    send0(xa, xb, 1'(i & 1), 4'(i),
                          mk(4'(i), fp_ref(2, 1, {4'h0, xa}, {4'h0, xb}, 1'(i & 1))));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!in_ready) saw_drop = 1'b1;
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        check("in_ready_drop", 32'(saw_drop), 32'd1);
        drain("drain_stream");
        @(posedge clk); #1;

        // reset with two ops in flight
        send0(4'h5, 4'h3, 1'b0, 4'd9, mk(4'd9, 9'h006));
        send0(4'h3, 4'h2, 1'b0, 4'd10, mk(4'd10, 9'h004));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_flush_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        outs_before = n_out0;
        repeat (8) @(negedge clk);
        check("rst_no_late_out", 32'(n_out0), 32'(outs_before));
        @(posedge clk); #1;
        send0(4'h7, 4'h1, 1'b0, 4'd11, mk(4'd11, 9'h007));
        lat_check("latency_after_rst");
        drain("drain_rst");
        @(posedge clk); #1;

        // exhaustive E2M1 sweep; random backpressure during the subtract half
        for (int s = 0; s < 2; s++) begin
            sweep_done = 1'b0;
            fork
                begin
                    for (int x = 0; x < 16; x++)
                        for (int y = 0; y < 16; y++)
                            send0(4'(x), 4'(y), 1'(s), 4'(x ^ y),
                                  mk(4'(x ^ y), fp_ref(2, 1, 8'(x), 8'(y), 1'(s))));
                    sweep_done = 1'b1;
                end
                begin
                    while (!sweep_done) begin
                        @(posedge clk); #1;
                        if (s == 1) out_ready = ($urandom_range(0, 3) != 0);
                    end
                    out_ready = 1'b1;
                end
            join
            drain("drain_sweep");
        end
        @(posedge clk); #1;

        // E4M3: hand-computed checks then random vectors
        send1(8'h38, 8'h38, 1'b0, 4'd1, mk(4'd1, 9'h040));
        send1(8'h7F, 8'h7F, 1'b0, 4'd2, mk(4'd2, 9'h17F));
        send1(8'h38, 8'h38, 1'b1, 4'd3, mk(4'd3, 9'h000));
        for (int i = 0; i < 300; i++) begin
            logic [7:0] xa, xb;
            logic       xs;
            xa = 8'($urandom_range(0, 255));
            xb = 8'($urandom_range(0, 255));
            xs = 1'($urandom_range(0, 1));
            send1(xa, xb, xs, 4'(i), mk(4'(i), fp_ref(4, 3, xa, xb, xs)));
        end
        drain("drain_wide");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
